// File: rtl/victim_control_if.sv
// L1/L2 handshake plus datapath select/status bundle for the victim cache controller.
interface victim_control_if;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;
    logic [7:0] Hit;
    logic [7:0] Valid;
    logic [7:0] Dirty;
    logic [7:0] write;
    logic [7:0] datainmux_sel;
    logic [2:0] dataoutmux_sel;
    logic [2:0] pmem_wdatamux_sel;
    logic [2:0] basemux_sel;
    logic       pmem_address_mux_sel;
    logic       valid_data;
    logic       dirty_data;

    modport master (
        input  mem_read, mem_write, pmem_resp, Hit, Valid, Dirty,
        output mem_resp, pmem_read, pmem_write, write, datainmux_sel,
               dataoutmux_sel, pmem_wdatamux_sel, basemux_sel,
               pmem_address_mux_sel, valid_data, dirty_data
    );

    modport slave (
        output mem_read, mem_write, pmem_resp, Hit, Valid, Dirty,
        input  mem_resp, pmem_read, pmem_write, write, datainmux_sel,
               dataoutmux_sel, pmem_wdatamux_sel, basemux_sel,
               pmem_address_mux_sel, valid_data, dirty_data
    );
endinterface

// File: rtl/victim_control.sv
// Controller for the 4-way fully associative victim cache: lookup, install, dirty writeback, true LRU.
// Optional hit/miss counters are enabled with the VICTIM_PERF_CNT_EN macro.
module victim_control #(
    parameter int NUM_WAYS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    victim_control_if.master  bus
`ifdef VICTIM_PERF_CNT_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WR_HIT,
        INSTALL,
        RD_HIT,
        L2_RD,
        WB
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] way_q, way_d;
    logic [1:0] age_q [NUM_WAYS];
    logic [1:0] age_d [NUM_WAYS];

    logic [3:0] hitVec;
    logic [3:0] validVec;
    logic [3:0] dirtyVec;
    logic       anyHit;
    logic [1:0] hitWay;
    logic [1:0] victimWay;
    logic       anyInvalid;
    logic       unusedStatus;

    assign hitVec       = bus.Hit[3:0] & bus.Valid[3:0];
    assign validVec     = bus.Valid[3:0];
    assign dirtyVec     = bus.Dirty[3:0];
    assign anyHit       = |hitVec;
    assign unusedStatus = ^{bus.Hit[7:4], bus.Valid[7:4], bus.Dirty[7:4]};

    // Lowest-index hit way; victim is the lowest invalid way, else the oldest (age 3).
    always_comb begin
        hitWay     = 2'd0;
        victimWay  = 2'd0;
        anyInvalid = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hitVec[i]) hitWay = 2'(i);
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (age_q[i] == 2'd3) victimWay = 2'(i);
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!validVec[i]) begin
                victimWay  = 2'(i);
                anyInvalid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        for (int i = 0; i < NUM_WAYS; i++) age_d[i] = age_q[i];

        unique case (state_q)
            IDLE: begin
                if (bus.mem_write) begin
                    if (anyHit) begin
                        state_d = WR_HIT;
                        way_d   = hitWay;
                    end else begin
                        way_d   = victimWay;
                        state_d = (!anyInvalid && dirtyVec[victimWay]) ? WB : INSTALL;
                    end
                end else if (bus.mem_read) begin
                    if (anyHit) begin
                        state_d = RD_HIT;
                        way_d   = hitWay;
                    end else begin
                        state_d = L2_RD;
                    end
                end
            end
            WR_HIT, INSTALL, RD_HIT: begin
                state_d = IDLE;
                for (int i = 0; i < NUM_WAYS; i++) begin
                    if (age_q[i] < age_q[way_q]) age_d[i] = age_q[i] + 2'd1;
                end
                age_d[way_q] = 2'd0;
            end
            L2_RD: begin
                if (bus.pmem_resp) state_d = IDLE;
            end
            WB: begin
                if (bus.pmem_resp) state_d = INSTALL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            way_q   <= 2'd0;
            for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= 2'(i);
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= age_d[i];
        end
    end

    logic [3:0] wayOneHot;
    assign wayOneHot = 4'b0001 << way_q;

    // Outputs decode from state and latched way only; L2_RD forwards pmem_resp as mem_resp.
    always_comb begin
        bus.mem_resp             = 1'b0;
        bus.pmem_read            = 1'b0;
        bus.pmem_write           = 1'b0;
        bus.write                = 8'h00;
        bus.datainmux_sel        = 8'h00;
        bus.dataoutmux_sel       = 3'd0;
        bus.pmem_wdatamux_sel    = 3'd0;
        bus.basemux_sel          = 3'd0;
        bus.pmem_address_mux_sel = 1'b0;
        bus.valid_data           = 1'b0;
        bus.dirty_data           = 1'b0;

        unique case (state_q)
            WR_HIT, INSTALL: begin
                bus.write         = {4'b0000, wayOneHot};
                bus.datainmux_sel = {4'b0000, wayOneHot};
                bus.valid_data    = 1'b1;
                bus.dirty_data    = 1'b1;
                bus.mem_resp      = 1'b1;
            end
            RD_HIT: begin
                bus.dataoutmux_sel = {1'b0, way_q};
                bus.mem_resp       = 1'b1;
            end
            L2_RD: begin
                bus.pmem_read      = 1'b1;
                bus.dataoutmux_sel = 3'd4;
                bus.mem_resp       = bus.pmem_resp;
            end
            WB: begin
                bus.pmem_write           = 1'b1;
                bus.pmem_address_mux_sel = 1'b1;
                bus.basemux_sel          = {1'b0, way_q};
                bus.pmem_wdatamux_sel    = {1'b0, way_q};
            end
            default: ;
        endcase
    end

`ifdef VICTIM_PERF_CNT_EN
    logic hitInc, missInc;
    assign hitInc  = (state_q == IDLE) && ((state_d == RD_HIT) || (state_d == WR_HIT));
    assign missInc = (state_q == IDLE) &&
                     ((state_d == L2_RD) || (state_d == WB) || (state_d == INSTALL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (hitInc && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
            if (missInc && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
